// File: rtl/base_parity_gen_buf.sv
// Parity generator with a registered two-entry skid buffer between upstream and downstream handshakes.
// Optional error injection on o_p[0] is enabled by defining BASE_PARITY_GEN_BUF_ERRINJ_EN.
module base_parity_gen_buf #(
  parameter int dwidth = 1,
  parameter int pwidth = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_v,
  output logic              i_r,
  input  logic [dwidth-1:0] i_d,
  output logic              o_v,
  input  logic              o_r,
  output logic [dwidth-1:0] o_d,
  output logic [pwidth-1:0] o_p
`ifdef BASE_PARITY_GEN_BUF_ERRINJ_EN
  ,
  input  logic              i_inj
`endif
);

  localparam int swidth = dwidth / pwidth;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } count_t;

  count_t            state_q, state_d;
  logic [dwidth-1:0] main_d_q, skid_d_q;
  logic [pwidth-1:0] main_p_q, skid_p_q;
  logic [pwidth-1:0] in_par, in_p;
  logic              accept, pop;
  logic              load_main_new, load_skid, skid_to_main;

  // Even parity per slice, taken from the incoming beat and stored alongside it.
  always_comb begin
    in_par = '0;
    for (int k = 0; k < pwidth; k++) begin
      in_par[k] = ^i_d[k*swidth +: swidth];
    end
  end

`ifdef BASE_PARITY_GEN_BUF_ERRINJ_EN
  logic inj_q;
  logic inj_now;

  // A request in the accepting cycle corrupts that same beat.
  assign inj_now = inj_q | i_inj;
  assign in_p    = in_par ^ pwidth'(inj_now);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inj_q <= 1'b0;
    end else if (accept) begin
      inj_q <= 1'b0;
    end else if (i_inj) begin
      inj_q <= 1'b1;
    end
  end
`else
  assign in_p = in_par;
`endif

  // Ready and valid decode only registered state, so o_r never reaches i_r.
  assign i_r    = (state_q != FULL);
  assign o_v    = (state_q != EMPTY);
  assign accept = i_v & i_r;
  assign pop    = o_v & o_r;
  assign o_d    = main_d_q;
  assign o_p    = main_p_q;

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_d       = state_q;
    load_main_new = 1'b0;
    load_skid     = 1'b0;
    skid_to_main  = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d       = ONE;
          load_main_new = 1'b1;
        end
      end
      ONE: begin
        if (accept && !pop) begin
          state_d   = FULL;
          load_skid = 1'b1;
        end else if (accept && pop) begin
          load_main_new = 1'b1;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          state_d      = ONE;
          skid_to_main = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      state_q <= state_d;
    end
  end

  // NOTE: the two storage entries are reset because o_d/o_p must read zero out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_d_q <= '0;
      main_p_q <= '0;
      skid_d_q <= '0;
      skid_p_q <= '0;
    end else begin
      if (load_main_new) begin
        main_d_q <= i_d;
        main_p_q <= in_p;
      end else if (skid_to_main) begin
        main_d_q <= skid_d_q;
        main_p_q <= skid_p_q;
      end
      if (load_skid) begin
        skid_d_q <= i_d;
        skid_p_q <= in_p;
      end
    end
  end

endmodule
